// File: rtl/mdu.sv
// Iterative 32-bit multiply/divide unit holding the HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU complete as one-cycle no-ops.
module mdu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        op_div;
    logic        neg_a;
    logic        neg_b;
    logic [4:0]  cnt;
    logic [63:0] acc;
    logic [31:0] opb;

    logic        signed_op;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] calc_next;
    logic [63:0] product;

`ifdef MDU_DIV_EN
    logic [31:0] a_orig;
    logic [32:0] div_top;
    logic [33:0] div_diff;
    logic [63:0] div_step;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
`endif

    assign busy      = (state != IDLE);
    assign signed_op = ~op[0];
    assign abs_a     = (signed_op && a[31]) ? (32'd0 - a) : a;
    assign abs_b     = (signed_op && b[31]) ? (32'd0 - b) : b;

    // Shift-add: low half holds the remaining multiplier bits, high half the partial product.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_step = {mul_sum, acc[31:1]};
    assign product  = (neg_a ^ neg_b) ? (64'd0 - acc) : acc;

`ifdef MDU_DIV_EN
    // Restoring divide on remainder:quotient; the shifted remainder may need 33 bits.
    assign div_top   = acc[63:31];
    assign div_diff  = {1'b0, div_top} - {2'b00, opb};
    assign div_step  = div_diff[33] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1};
    assign calc_next = op_div ? div_step : mul_step;
    assign quot_fix  = (neg_a ^ neg_b) ? (32'd0 - acc[31:0]) : acc[31:0];
    assign rem_fix   = neg_a ? (32'd0 - acc[63:32]) : acc[63:32];
`else
    assign calc_next = mul_step;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MDU_DIV_EN
                    state_next = CALC;
`else
                    state_next = op[1] ? FIX : CALC;
`endif
                end
            end
            CALC: begin
                if (cnt == 5'd31) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opb    <= 32'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
`ifdef MDU_DIV_EN
            a_orig <= 32'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_div <= op[1];
                        neg_a  <= signed_op & a[31];
                        neg_b  <= signed_op & b[31];
                        cnt    <= 5'd0;
                        acc    <= {32'd0, abs_a};
                        opb    <= abs_b;
`ifdef MDU_DIV_EN
                        a_orig <= a;
`endif
                    end else begin
                        if (mthi) begin
                            hi <= a;
                        end
                        if (mtlo) begin
                            lo <= a;
                        end
                    end
                end
                CALC: begin
                    acc <= calc_next;
                    cnt <= cnt + 5'd1;
                end
                FIX: begin
                    done <= 1'b1;
                    if (!op_div) begin
                        hi <= product[63:32];
                        lo <= product[31:0];
                    end
`ifdef MDU_DIV_EN
                    // A zero divisor leaves an all-ones quotient; HI reports the untouched dividend.
                    else if (opb == 32'd0) begin
                        hi <= a_orig;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the general-purpose register file and takes its two read-port values as operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in the architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
- No parameters; data width is fixed at 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: launch the operation selected by `op`; sampled only when `busy`=0.
- `op` input 2: 2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- `a` input 32: rs operand, register file read port A; multiplicand or dividend.
- `b` input 32: rt operand, register file read port B; multiplier or divisor.
- `mthi` input 1: write `a` to HI when idle.
- `mtlo` input 1: write `a` to LO when idle.
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when HI/LO have just been updated by an operation.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- State machine: IDLE → CALC → FIX → IDLE.
- **IDLE, `start`=1:**
  - Latch `op`.
  - Latch |a| and |b| for signed ops (plain values for unsigned ops).
  - Record the operand signs.
  - Clear the 5-bit iteration counter and go to CALC.
- **CALC:** one iteration per cycle, 32 iterations total.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; 64-bit remainder:quotient register.
  - Leave CALC when the counter equals 31 after that iteration.
- **FIX:** perform sign correction, write HI/LO, return to IDLE.
  - Signed multiply: negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
  - Signed divide: quotient negated if the signs differ; remainder takes the sign of the dividend. LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0. This is the natural wrap result; no trap is raised.
  - Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = the original `a`. The full latency still applies.
- **MTHI/MTLO:**
  - Honoured only in IDLE with `start`=0.
  - `mthi` and `mtlo` asserted together write `a` to both registers.
  - Ignored while `busy`.
- **Priority when idle:** `start` wins; a simultaneous `mthi`/`mtlo` is dropped.
- `start` while `busy` is ignored. No queueing; the current operation is unaffected.
- HI/LO hold their previous values throughout CALC and change only at the FIX edge.

## Timing
- **Reset** (`rst_n`=0 at an edge): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
  - Reset mid-operation aborts the operation; no HI/LO write occurs.
- **Edge E0**, `start` accepted: `busy`=1 from E0.
- **Edges E1..E32:** the 32 iterations.
- **Edge E33:** FIX executes.
  - `hi`/`lo` take the new values.
  - `busy`=0.
  - `done`=1 for exactly the cycle following E33.
- Latency is 33 cycles from the accepting edge to valid HI/LO.
- A new `start` is accepted at E33+1 at the earliest (back-to-back operations are allowed).
- MTHI/MTLO write takes effect at the sampling edge. `done` is not asserted for MTHI/MTLO.
- `hi`/`lo` are driven directly from registers; there is no combinational path from inputs.

## Configuration
- **`MDU_DIV_EN` defined:** the full divide datapath is built and behaves as described above.
- **`MDU_DIV_EN` undefined:** the divide datapath is removed.
  - DIV/DIVU `start` is accepted; `busy`=1 for one cycle.
  - `done` pulses in the cycle after the next edge.
  - HI/LO are unchanged.
  - Multiply behaviour and timing are identical to the `MDU_DIV_EN` build.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, one `done` pulse.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → lo=0xFFFFFFFF, hi=0x00000064 at E33.
- Busy-interaction sequence, in order:
  - Start MULTU 3×4.
  - Assert `start` and `mthi` (a=0xDEAD) at cycle 10 → both ignored; result hi=0, lo=12.
  - Then MTLO a=0x1234 when idle → lo=0x1234 next edge, no `done` pulse.
- Prime HI/LO = 7/9 via MTHI/MTLO; start DIVU; drop `rst_n` at cycle 15 → hi=0, lo=0, `busy`=0, no `done` pulse; then a fresh MULTU 2×3 yields lo=6.
